// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - consumer-side bus of the UART receive FIFO
//
// Signals:
//   rx_data     8                    head-of-FIFO byte, valid while rx_valid=1
//   rx_valid    1                    FIFO non-empty
//   rx_ready    1                    consumer takes the head byte
//   fifo_count  $clog2(FIFO_DEPTH)+1 entries currently held
//   frame_err   1                    sticky framing/parity error
//   overflow    1                    sticky dropped-byte flag
//   clear_err   1                    one-cycle pulse clearing both flags
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          overflow;
    logic          clear_err;

    modport master (
        output rx_data, rx_valid, fifo_count, frame_err, overflow,
        input  rx_ready, clear_err
    );

    modport slave (
        input  rx_data, rx_valid, fifo_count, frame_err, overflow,
        output rx_ready, clear_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a small byte FIFO
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   rx     in   serial input, idle high, LSB first
//   rx_if  master modport of uart_rx_fifo_if (data/valid/ready, count,
//          sticky frame_err/overflow, clear_err)
// Parameters: CLKS_PER_BIT (even, >= 4), FIFO_DEPTH (power of two, >= 2).
// Option: define UART_RX_PARITY_EN to expect an even-parity bit after bit 7.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx,
    uart_rx_fifo_if.master rx_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY  = 3'd5
`endif
    } state_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CW-1:0]    r_count;
    logic [7:0]       r_rx_data;
    logic             r_frame_err;
    logic             r_overflow;

    logic             w_tick_half;
    logic             w_tick_bit;
    logic             w_stop_sample;
    logic             w_par_bad;
    logic             w_par_err;
    logic             w_push;
    logic             w_ferr_set;
    logic             w_valid;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic             w_ovf_set;
    logic [CW-1:0]    w_cnt_after_pop;

    // Both stages reset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick_half   = (r_clk_cnt == CNT_W'(HALF - 1));
    assign w_tick_bit    = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_stop_sample = (r_state == S_STOP) && w_tick_bit;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    assign w_par_bad = r_par_bad;
    // Even parity: XOR over data and parity bit must be zero.
    assign w_par_err = (r_state == S_PARITY) && w_tick_bit && (^{r_shift, r_rx_s});
`else
    assign w_par_bad = 1'b0;
    assign w_par_err = 1'b0;
`endif

    assign w_push     = w_stop_sample && r_rx_s && !w_par_bad;
    assign w_ferr_set = (w_stop_sample && !r_rx_s) || w_par_err;

    // The cycle rx_s is first seen low counts as tick 0, so the counter
    // enters START at 1 and the start sample lands on t0+HALF-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_clk_cnt <= CNT_W'(1);
                        r_bit_idx <= '0;
                    end
                end
                S_START: begin
                    if (w_tick_half) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick_bit) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick_bit) begin
                        r_clk_cnt <= '0;
                        r_par_bad <= ^{r_shift, r_rx_s};
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick_bit) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        r_par_bad <= 1'b0;
`endif
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must return high before a new start.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_valid         = (r_count != '0);
    assign w_pop           = w_valid && rx_if.rx_ready;
    assign w_full          = (r_count == CW'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_wr            = w_push && (!w_full || w_pop);
    assign w_ovf_set       = w_push && w_full && !w_pop;
    assign w_cnt_after_pop = r_count - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    // rx_data is preloaded with the next head so it is valid the cycle
    // rx_valid rises, without a combinational path from rx_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rx_data <= 8'h00;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            if (w_cnt_after_pop != '0) begin
                r_rx_data <= r_mem[r_rptr + PTR_W'(w_pop)];
            end else if (w_wr) begin
                r_rx_data <= r_shift;
            end
        end
    end

    // A new error in the clear cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end else if (rx_if.clear_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (rx_if.clear_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = r_rx_data;
    assign rx_if.rx_valid   = w_valid;
    assign rx_if.fifo_count = r_count;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.overflow   = r_overflow;
endmodule
